// File: rtl/pll_lock_rst_seq.sv
// Reset sequencer behind the CNN-clock PLL: pulses the PLL reset, qualifies the synchronised lock,
// and releases the CNN datapath reset once lock is stable. All outputs come straight from flops.
module pll_lock_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic             cnn_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_RT = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC   = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [1:0]       sync_q;
    logic             pll_rst_q;
    logic             run_q;
    logic             lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        tcnt_d  = tcnt_q;
        lcnt_d  = lcnt_q;
        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_WAIT_LOCK: begin
                if (soft_rst_req) begin
                    state_d = S_PLL_RST;
                end else if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_PLL_RST;
                    if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STABLE: begin
                if (soft_rst_req)              state_d = S_PLL_RST;
                else if (!lock_s)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
                else                           cnt_d   = cnt_q + CW'(1);
            end
            S_RUN: begin
                // A lock drop is counted even when a soft request arrives together with it.
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    if (lcnt_q != CNT_MAX) lcnt_d = lcnt_q + CNT_W'(1);
                end else if (soft_rst_req) begin
                    state_d = S_PLL_RST;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            lcnt_q    <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            lcnt_q    <= lcnt_d;
            sync_q    <= {sync_q[0], pll_locked};
            pll_rst_q <= (state_d == S_PLL_RST);
            run_q     <= (state_d == S_RUN);
        end
    end

    assign state         = state_q;
    assign pll_rst       = pll_rst_q;
    assign ready         = run_q;
    assign cnn_rst_n     = run_q;
    assign timeout_cnt   = tcnt_q;
    assign lock_loss_cnt = lcnt_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq with shortened timing: vector table plus corner-case sequences,
// expected results queued at drive time and popped when the outputs are sampled.
module tb_pll_lock_rst_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 3;

    logic             clk;
    logic             reset_n;
    logic             pll_locked;
    logic             soft_rst_req;
    logic             pll_rst;
    logic             cnn_rst_n;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] lock_loss_cnt;

    pll_lock_rst_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .cnn_rst_n    (cnn_rst_n),
        .ready        (ready),
        .state        (state),
        .timeout_cnt  (timeout_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs held for n clock edges, then the outputs expected after the last edge.
    typedef struct {
        int rn;
        int lk;
        int sr;
        int n;
        int st;
        int prst;
        int rdy;
        int tc;
        int lc;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   row    = 0;

    function automatic vec_t mk(int rn, int lk, int sr, int n, int st, int prst, int rdy, int tc, int lc);
        vec_t v;
        v.rn = rn; v.lk = lk; v.sr = sr; v.n = n;
        v.st = st; v.prst = prst; v.rdy = rdy; v.tc = tc; v.lc = lc;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, nm, act, exp);
        end
    endtask

    task automatic run_row(vec_t v);
        vec_t e;
        reset_n      = v.rn[0];
        pll_locked   = v.lk[0];
        soft_rst_req = v.sr[0];
        sb.push_back(v);
        repeat (v.n) @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state",         int'(state),         e.st);
        chk("pll_rst",       int'(pll_rst),       e.prst);
        chk("ready",         int'(ready),         e.rdy);
        chk("cnn_rst_n",     int'(cnn_rst_n),     e.rdy);
        chk("timeout_cnt",   int'(timeout_cnt),   e.tc);
        chk("lock_loss_cnt", int'(lock_loss_cnt), e.lc);
        row++;
    endtask

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;

        // Reset, then a clean power-up with lock present throughout.
        tbl.push_back(mk(0, 1, 0, 2,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1,  2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 7,  2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1,  3, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 20, 3, 0, 1, 0, 0));
        // Lock drop in RUN: visible on the third edge, then relock.
        tbl.push_back(mk(1, 0, 0, 2,  3, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 12, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,  3, 0, 1, 0, 1));
        // Soft request in RUN; a second one during PLL_RST must not stretch the pulse.
        tbl.push_back(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,  1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,  2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 8,  3, 0, 1, 0, 1));

        foreach (tbl[i]) run_row(tbl[i]);

        // Three-cycle lock glitch at stable count 3 restarts the full qualification.
        run_row(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        run_row(mk(1, 1, 0, 8,  2, 0, 0, 0, 1));
        run_row(mk(1, 0, 0, 3,  1, 0, 0, 0, 1));
        run_row(mk(1, 1, 0, 2,  1, 0, 0, 0, 1));
        run_row(mk(1, 1, 0, 1,  2, 0, 0, 0, 1));
        run_row(mk(1, 1, 0, 7,  2, 0, 0, 0, 1));
        run_row(mk(1, 1, 0, 1,  3, 0, 1, 0, 1));

        // Soft request beats lock in WAIT_LOCK and beats release on the last STABLE cycle.
        run_row(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        run_row(mk(1, 1, 0, 4,  1, 0, 0, 0, 1));
        run_row(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        run_row(mk(1, 1, 0, 12, 2, 0, 0, 0, 1));
        run_row(mk(1, 1, 1, 1,  0, 1, 0, 0, 1));
        run_row(mk(1, 1, 0, 13, 3, 0, 1, 0, 1));

        // No lock: 20-cycle timeout period, timeout_cnt saturates at 7.
        run_row(mk(1, 0, 0, 3,   0, 1, 0, 0, 2));
        run_row(mk(1, 0, 0, 19,  1, 0, 0, 0, 2));
        run_row(mk(1, 0, 0, 1,   0, 1, 0, 1, 2));
        run_row(mk(1, 0, 0, 120, 0, 1, 0, 7, 2));
        run_row(mk(1, 0, 0, 20,  0, 1, 0, 7, 2));
        run_row(mk(1, 0, 0, 60,  0, 1, 0, 7, 2));
        run_row(mk(1, 1, 0, 13,  3, 0, 1, 7, 2));

        // Lock drop and soft request sampled together still count as a lock loss.
        run_row(mk(1, 0, 0, 2,  3, 0, 1, 7, 2));
        run_row(mk(1, 0, 1, 1,  0, 1, 0, 7, 3));
        run_row(mk(1, 1, 0, 13, 3, 0, 1, 7, 3));

        // Repeated drops drive lock_loss_cnt into saturation.
        for (int i = 0; i < 5; i++) begin
            run_row(mk(1, 0, 0, 3,  0, 1, 0, 7, (4 + i > 7) ? 7 : 4 + i));
            run_row(mk(1, 1, 0, 13, 3, 0, 1, 7, (4 + i > 7) ? 7 : 4 + i));
        end

        // One-cycle reset in RUN clears everything; power-up sequence repeats.
        run_row(mk(0, 1, 0, 1,  0, 1, 0, 0, 0));
        run_row(mk(1, 1, 0, 12, 2, 0, 0, 0, 0));
        run_row(mk(1, 1, 0, 1,  3, 0, 1, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
